fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_queue.sv | 57 +++++
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch unit.
package fetch_pkg;

  // Byte distance between consecutive instruction words.
  localparam int unsigned PC_STEP = 4;

  // Boot address used when the instantiating block does not override it.
  localparam longint unsigned DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: circular buffer of fetched {inst, pc, pc_next} entries.
// Full/empty come from the occupancy counter so pointer equality is never
// ambiguous.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 96
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             full, empty, do_push, do_pop;

  assign full    = (occ == OCC_W'(DEPTH));
  assign empty   = (occ == '0);
  // A push into a full queue is only legal when the head leaves this cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; flush drops everything at once.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Entry storage; contents are meaningless outside the occupied window.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head      = mem[rd_ptr];
  assign occupancy = occ;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetches, tracks the single
// outstanding read, and buffers returned words in a prefetch queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       inst_ren,
  output logic [ADDR_W-1:0]          inst_addr,
  input  logic [INST_W-1:0]          inst_data,
  input  logic                       redirect_en,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INST_W-1:0]          out_inst,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [ADDR_W-1:0]          out_pc_next,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int PLD_W = INST_W + 2*ADDR_W;

  typedef enum logic {BOOT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              inflight;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W:0]    pending;
  logic              room;
  logic              push, pop;
  logic [PLD_W-1:0]  push_data, head;

  // Count the outstanding read against capacity so its response always fits.
  assign pending = {1'b0, occ} + (OCC_W+1)'(inflight);
  assign room    = pending < (OCC_W+1)'(DEPTH);

  assign inst_ren  = rst_n && (state == RUN) && !redirect_en && room;
  assign inst_addr = rst_n ? pc : RESET_PC;

  // A redirect kills the response arriving this cycle.
  assign push      = rst_n && inflight && !redirect_en;
  assign push_data = {inst_data, req_pc, req_pc + ADDR_W'(PC_STEP)};

  assign out_valid = rst_n && (occ != '0);
  assign pop       = out_valid && out_ready;

  // FSM, fetch PC and outstanding-request tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        default: state <= RUN;
      endcase
      inflight <= inst_ren;
      if (inst_ren) req_pc <= pc;
      if (redirect_en)   pc <= redirect_pc;
      else if (inst_ren) pc <= pc + ADDR_W'(PC_STEP);
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .W     (PLD_W)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_en),
    .head      (head),
    .occupancy (occ)
  );

  assign out_inst    = head[PLD_W-1 -: INST_W];
  assign out_pc      = head[2*ADDR_W-1 -: ADDR_W];
  assign out_pc_next = head[ADDR_W-1:0];
  assign occupancy   = occ;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: startup, back-pressure, redirects,
// address wrap and mid-stream reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc_next;
  logic [2:0]  occupancy;

  logic        w_ren;
  logic [15:0] w_addr;
  logic [31:0] w_data;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [15:0] w_pc;
  logic [15:0] w_pc_next;
  logic [2:0]  w_occ;

  int n_cmp = 0;
  int n_err = 0;
  logic found;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .inst_ren(inst_ren), .inst_addr(inst_addr),
    .inst_data(inst_data), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_pc_next(out_pc_next), .occupancy(occupancy)
  );

  fetch_unit #(.ADDR_W(16), .INST_W(32), .DEPTH(4), .RESET_PC(16'hFFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .inst_ren(w_ren), .inst_addr(w_addr),
    .inst_data(w_data), .redirect_en(1'b0), .redirect_pc(16'h0),
    .out_valid(w_valid), .out_ready(1'b1), .out_inst(w_inst),
    .out_pc(w_pc), .out_pc_next(w_pc_next), .occupancy(w_occ)
  );

  // Instruction memory: word at addr reads as 0x1000_0000 + addr, one cycle later.
  always @(posedge clk) begin
    if (inst_ren) inst_data <= 32'h1000_0000 + inst_addr;
    if (w_ren)    w_data    <= 32'h1000_0000 + {16'h0, w_addr};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; redirect_en = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ren", inst_ren, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", inst_addr, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_w_addr", w_addr, 16'hFFF8);

    // Startup: BOOT cycle, then sequential fetch from RESET_PC.
    rst_n = 1'b1; #1;
    chk("boot_ren", inst_ren, 0);
    chk("boot_w_ren", w_ren, 0);
    nxt();
    chk("p1_ren", inst_ren, 1);
    chk("p1_addr", inst_addr, 32'h0);
    chk("p1_w_addr", w_addr, 16'hFFF8);
    nxt();
    chk("p2_addr", inst_addr, 32'h4);
    chk("p2_valid", out_valid, 0);
    chk("p2_w_addr", w_addr, 16'hFFFC);
    nxt();
    chk("p3_addr", inst_addr, 32'h8);
    chk("p3_valid", out_valid, 1);
    chk("p3_pc", out_pc, 32'h0);
    chk("p3_pc_next", out_pc_next, 32'h4);
    chk("p3_inst", out_inst, 32'h1000_0000);
    chk("p3_w_addr", w_addr, 16'h0000);
    chk("p3_w_pc", w_pc, 16'hFFF8);
    nxt();
    chk("p4_pc", out_pc, 32'h4);
    chk("p4_occ", occupancy, 1);
    chk("p4_w_pc", w_pc, 16'hFFFC);
    chk("p4_w_pc_next", w_pc_next, 16'h0000);

    // Back-pressure from a fresh reset.
    rst_n = 1'b0; out_ready = 1'b0;
    nxt();
    rst_n = 1'b1;
    repeat (5) nxt();
    chk("bp_p5_ren", inst_ren, 0);
    chk("bp_p5_occ", occupancy, 3);
    repeat (5) nxt();
    chk("bp_occ_full", occupancy, 4);
    chk("bp_ren", inst_ren, 0);
    chk("bp_addr_hold", inst_addr, 32'h10);
    out_ready = 1'b1; #1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_pc", out_pc, 64'(4 * i));
      nxt();
    end

    // Redirect with 3 queued entries and one response in flight.
    rst_n = 1'b0; out_ready = 1'b0;
    nxt();
    rst_n = 1'b1;
    repeat (5) nxt();
    chk("rd_pre_occ", occupancy, 3);
    redirect_en = 1'b1; redirect_pc = 32'h200; #1;
    chk("rd_ren_blocked", inst_ren, 0);
    nxt();
    redirect_en = 1'b0; out_ready = 1'b1; #1;
    chk("rd_t1_occ", occupancy, 0);
    chk("rd_t1_valid", out_valid, 0);
    chk("rd_t1_addr", inst_addr, 32'h200);
    chk("rd_t1_ren", inst_ren, 1);
    nxt();
    chk("rd_t2_valid", out_valid, 0);
    nxt();
    chk("rd_t3_valid", out_valid, 1);
    chk("rd_t3_pc", out_pc, 32'h200);
    chk("rd_t3_inst", out_inst, 32'h1000_0200);
    nxt();
    chk("rd_t4_pc", out_pc, 32'h204);
    chk("rd_t4_occ", occupancy, 1);

    // Redirect while a push and a pop both happen.
    redirect_en = 1'b1; redirect_pc = 32'h300;
    nxt();
    redirect_en = 1'b0; #1;
    chk("rpp_occ", occupancy, 0);
    chk("rpp_valid", out_valid, 0);
    chk("rpp_addr", inst_addr, 32'h300);
    nxt();
    chk("rpp_t2_valid", out_valid, 0);
    nxt();
    chk("rpp_t3_valid", out_valid, 1);
    chk("rpp_t3_pc", out_pc, 32'h300);

    // Mid-stream reset with a full queue.
    out_ready = 1'b0;
    repeat (8) nxt();
    chk("mr_occ_full", occupancy, 4);
    rst_n = 1'b0; #1;
    chk("mr_ren", inst_ren, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_addr", inst_addr, 32'h0);
    nxt();
    chk("mr_occ", occupancy, 0);
    rst_n = 1'b1; out_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      nxt();
      if (out_valid) found = 1'b1;
    end
    chk("mr_seen", found, 1);
    chk("mr_first_pc", out_pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
